// File: rtl/isqrt_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_arb_pkg
// Description : Shared types, defaults and round-robin grant helper for the
//               isqrt sharing arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package isqrt_arb_pkg;

  // Default number of requesters sharing one isqrt instance
  localparam int N_REQ_DEFAULT = 3;

  // Widest requester count the grant helper can scan
  localparam int MAX_REQ = 8;

  typedef logic [31:0] operand_t;
  typedef logic [15:0] result_t;

  typedef struct packed {
    logic       found;
    logic [2:0] id;
  } grant_t;

  // First set bit of pending at or after ptr, wrapping modulo n.
  // The scan runs from the farthest slot back to ptr so the closest one wins.
  function automatic grant_t rr_next_grant(input logic [MAX_REQ-1:0] pending,
                                           input logic [2:0]         ptr,
                                           input logic [3:0]         n);
    grant_t     g;
    logic [3:0] idx;
    g.found = 1'b0;
    g.id    = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (4'(k) < n) begin
        idx = {1'b0, ptr} + 4'(k);
        if (idx >= n) begin
          idx = idx - n;
        end
        if (pending[idx[2:0]]) begin
          g.found = 1'b1;
          g.id    = idx[2:0];
        end
      end
    end
    return g;
  endfunction

endpackage : isqrt_arb_pkg
`default_nettype wire

// File: rtl/isqrt_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_share_arbiter_if
// Description : Requester-side and isqrt-side signals of the sharing arbiter.
//               The arbiter uses the slave view; the environment uses master.
// Revision    : 1.0 - initial release
// ============================================================================
interface isqrt_share_arbiter_if
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
);

  // Requester side
  logic     [N_REQ-1:0] req_x_vld;
  operand_t [N_REQ-1:0] req_x;
  logic     [N_REQ-1:0] req_y_vld;
  result_t              req_y;

  // isqrt side
  logic                 isqrt_x_vld;
  operand_t             isqrt_x;
  logic                 isqrt_y_vld;
  result_t              isqrt_y;

  // Status
  logic                 busy;
  logic                 err;

  modport slave (
    input  req_x_vld, req_x, isqrt_y_vld, isqrt_y,
    output req_y_vld, req_y, isqrt_x_vld, isqrt_x, busy, err
  );

  modport master (
    output req_x_vld, req_x, isqrt_y_vld, isqrt_y,
    input  req_y_vld, req_y, isqrt_x_vld, isqrt_x, busy, err
  );

endinterface : isqrt_share_arbiter_if
`default_nettype wire

// File: rtl/isqrt_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_tag_fifo
// Description : Small in-order FIFO holding the requester ID of each isqrt
//               operation in flight. Depth need not be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; a pop frees room for a same-cycle push
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : isqrt_tag_fifo
`default_nettype wire

// File: rtl/isqrt_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_share_arbiter
// Description : Shares one pipelined isqrt among N_REQ requesters. Requests are
//               parked in per-requester slots, issued round-robin, tagged in an
//               in-order FIFO and the results routed back by tag.
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_share_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  isqrt_share_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(N_REQ);

  // Slot and return-path state
  operand_t           slot_q [N_REQ];
  operand_t           slot_d [N_REQ];
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [N_REQ-1:0]   outstanding_q, outstanding_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]   ret_vld_q, ret_vld_d;
  result_t            ret_y_q, ret_y_d;
  logic               err_q, err_d;

  // Grant and tag FIFO signals
  logic [MAX_REQ-1:0] pend_ext;
  logic [2:0]         ptr_ext;
  grant_t             gnt;
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_id;
  logic               fifo_pop;
  logic [ID_W-1:0]    fifo_head;
  logic               fifo_empty;
  logic               fifo_full;

  // Round-robin grant over the registered pending set
  always_comb begin
    pend_ext                = '0;
    pend_ext[N_REQ-1:0]     = pending_q;
    ptr_ext                 = '0;
    ptr_ext[ID_W-1:0]       = rr_ptr_q;
    gnt                     = rr_next_grant(pend_ext, ptr_ext, 4'(N_REQ));
    gnt_found               = gnt.found;
    gnt_id                  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt.id == 3'(i)) begin
        gnt_id = ID_W'(i);
      end
    end
  end

  assign fifo_pop = bus.isqrt_y_vld && !fifo_empty;

  isqrt_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (N_REQ)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (gnt_found),
    .push_data (gnt_id),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Issue bookkeeping, result routing, slot capture and protocol error detection
  always_comb begin
    slot_d        = slot_q;
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    rr_ptr_d      = rr_ptr_q;
    ret_vld_d     = '0;
    ret_y_d       = ret_y_q;
    err_d         = err_q;

    if (gnt_found) begin
      pending_d[gnt_id] = 1'b0;
      rr_ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    if (fifo_pop) begin
      ret_vld_d[fifo_head]     = 1'b1;
      ret_y_d                  = bus.isqrt_y;
      outstanding_d[fifo_head] = 1'b0;
    end

    // A result with no tag waiting cannot belong to anyone
    if (bus.isqrt_y_vld && fifo_empty) begin
      err_d = 1'b1;
    end

    // A requester with an operation still in flight may not request again
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_x_vld[i]) begin
        if (outstanding_q[i]) begin
          err_d = 1'b1;
        end else begin
          slot_d[i]        = bus.req_x[i];
          pending_d[i]     = 1'b1;
          outstanding_d[i] = 1'b1;
        end
      end
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        slot_q[i] <= '0;
      end
      pending_q     <= '0;
      outstanding_q <= '0;
      rr_ptr_q      <= '0;
      ret_vld_q     <= '0;
      ret_y_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      rr_ptr_q      <= rr_ptr_d;
      ret_vld_q     <= ret_vld_d;
      ret_y_q       <= ret_y_d;
      err_q         <= err_d;
    end
  end

  assign bus.isqrt_x_vld = gnt_found;
  assign bus.isqrt_x     = gnt_found ? slot_q[gnt_id] : '0;
  assign bus.req_y_vld   = ret_vld_q;
  assign bus.req_y       = ret_y_q;
  assign bus.err         = err_q;
  assign bus.busy        = (|pending_q) || !fifo_empty;

  // At most one tag per requester is ever in flight, so the FIFO cannot overflow
  a_no_tag_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(gnt_found && fifo_full && !fifo_pop));

endmodule : isqrt_share_arbiter
`default_nettype wire

// File: tb/tb_isqrt_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_isqrt_share_arbiter
// Description : Self-checking bench for isqrt_share_arbiter with a 4-cycle
//               pipelined isqrt stand-in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isqrt_share_arbiter;
  import isqrt_arb_pkg::*;

  localparam int N = 3;
  localparam int L = 4;

  logic clk;
  logic rst_n;
  logic spur;
  int   checks;
  int   failures;

  isqrt_share_arbiter_if #(.N_REQ(N)) bus ();

  isqrt_share_arbiter #(.N_REQ(N)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference integer square root used by the isqrt stand-in
  function automatic result_t f_isqrt(input operand_t x);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if ({32'd0, t} * {32'd0, t} <= {32'd0, x}) begin
        r = t;
      end
    end
    return r;
  endfunction

  // Fixed-latency in-order isqrt stand-in sharing the arbiter reset
  logic [L-1:0] pv;
  result_t      py [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < L; i++) py[i] <= '0;
    end else begin
      pv    <= {pv[L-2:0], bus.isqrt_x_vld};
      py[0] <= f_isqrt(bus.isqrt_x);
      for (int i = 1; i < L; i++) py[i] <= py[i-1];
    end
  end
  assign bus.isqrt_y_vld = pv[L-1] | spur;
  assign bus.isqrt_y     = py[L-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    spur          = 1'b0;
    bus.req_x_vld = '0;
    bus.req_x     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int       id;
    operand_t x;
    result_t  exp_y;
  } vec_t;

  vec_t vecs [9];
  int   n;
  int   cnt_a;
  int   cnt_b;
  int   cnt_bad;
  int   r2_issue;

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{0, 32'd0,          16'd0};
    vecs[1] = '{1, 32'd1,          16'd1};
    vecs[2] = '{2, 32'd2,          16'd1};
    vecs[3] = '{0, 32'd99,         16'd9};
    vecs[4] = '{1, 32'd100,        16'd10};
    vecs[5] = '{2, 32'd65535,      16'd255};
    vecs[6] = '{0, 32'd65536,      16'd256};
    vecs[7] = '{1, 32'hFFFF_FFFF,  16'd65535};
    vecs[8] = '{2, 32'd1024,       16'd32};

    // ---- reset state ----
    rst_n         = 1'b0;
    spur          = 1'b0;
    bus.req_x_vld = '0;
    bus.req_x     = '0;
    #12;
    chk("rst_req_y_vld",   64'(bus.req_y_vld),   64'(0));
    chk("rst_req_y",       64'(bus.req_y),       64'(0));
    chk("rst_isqrt_x_vld", 64'(bus.isqrt_x_vld), 64'(0));
    chk("rst_isqrt_x",     64'(bus.isqrt_x),     64'(0));
    chk("rst_busy",        64'(bus.busy),        64'(0));
    chk("rst_err",         64'(bus.err),         64'(0));

    // ---- single request, x=49 ----
    do_reset();
    bus.req_x_vld[0] = 1'b1;
    bus.req_x[0]     = 32'd49;
    step();
    bus.req_x_vld = '0;
    chk("single_issue_vld", 64'(bus.isqrt_x_vld), 64'(1));
    chk("single_issue_x",   64'(bus.isqrt_x),     64'(49));
    chk("single_busy_c1",   64'(bus.busy),        64'(1));
    repeat (4) step();
    chk("single_busy_c5",   64'(bus.busy),        64'(1));
    chk("single_novld_c5",  64'(bus.req_y_vld),   64'(0));
    step();
    chk("single_y_vld_c6",  64'(bus.req_y_vld),   64'(3'b001));
    chk("single_y_c6",      64'(bus.req_y),       64'(7));
    chk("single_busy_c6",   64'(bus.busy),        64'(0));
    step();
    chk("single_vld_drop",  64'(bus.req_y_vld),   64'(0));

    // ---- table of single requests ----
    for (int v = 0; v < 9; v++) begin
      bus.req_x_vld             = '0;
      bus.req_x_vld[vecs[v].id] = 1'b1;
      bus.req_x[vecs[v].id]     = vecs[v].x;
      step();
      bus.req_x_vld = '0;
      n = 1;
      while (bus.req_y_vld == '0 && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("vec%0d_latency", v), 64'(n),             64'(6));
      chk($sformatf("vec%0d_onehot", v),  64'(bus.req_y_vld), 64'(3'b001 << vecs[v].id));
      chk($sformatf("vec%0d_value", v),   64'(bus.req_y),     64'(vecs[v].exp_y));
      step();
    end

    // ---- three requests in one cycle ----
    do_reset();
    bus.req_x_vld = 3'b111;
    bus.req_x[0]  = 32'd16;
    bus.req_x[1]  = 32'd81;
    bus.req_x[2]  = 32'd144;
    step();
    bus.req_x_vld = '0;
    chk("tri_issue0_x", 64'(bus.isqrt_x), 64'(16));
    step();
    chk("tri_issue1_x", 64'(bus.isqrt_x), 64'(81));
    step();
    chk("tri_issue2_x", 64'(bus.isqrt_x), 64'(144));
    chk("tri_issue2_v", 64'(bus.isqrt_x_vld), 64'(1));
    step();
    chk("tri_idle_c4",  64'(bus.isqrt_x_vld), 64'(0));
    repeat (2) step();
    chk("tri_res0_vld", 64'(bus.req_y_vld), 64'(3'b001));
    chk("tri_res0_y",   64'(bus.req_y),     64'(4));
    step();
    chk("tri_res1_vld", 64'(bus.req_y_vld), 64'(3'b010));
    chk("tri_res1_y",   64'(bus.req_y),     64'(9));
    step();
    chk("tri_res2_vld", 64'(bus.req_y_vld), 64'(3'b100));
    chk("tri_res2_y",   64'(bus.req_y),     64'(12));
    step();
    chk("tri_busy_end", 64'(bus.busy), 64'(0));

    // ---- fairness: requester 0 saturates, requester 2 asks once ----
    do_reset();
    cnt_a    = 0;
    cnt_b    = 0;
    cnt_bad  = 0;
    r2_issue = -1;
    for (int c = 0; c < 100; c++) begin
      bus.req_x_vld = '0;
      if (c == 0 || bus.req_y_vld[0]) begin
        bus.req_x_vld[0] = 1'b1;
        bus.req_x[0]     = 32'd4;
      end
      if (c == 6) begin
        bus.req_x_vld[2] = 1'b1;
        bus.req_x[2]     = 32'd9;
      end
      if (bus.req_y_vld[0]) begin
        cnt_a++;
        if (bus.req_y != 16'd2) cnt_bad++;
      end
      if (bus.req_y_vld[2]) begin
        cnt_b++;
        if (bus.req_y != 16'd3) cnt_bad++;
      end
      if (bus.isqrt_x_vld && bus.isqrt_x == 32'd9) r2_issue = c;
      step();
    end
    bus.req_x_vld = '0;
    repeat (10) step();
    chk("fair_r2_issue_cycle", 64'(r2_issue), 64'(7));
    chk("fair_r2_results",     64'(cnt_b),    64'(1));
    chk("fair_r0_results",     64'(cnt_a),    64'(16));
    chk("fair_bad_values",     64'(cnt_bad),  64'(0));
    chk("fair_err",            64'(bus.err),  64'(0));

    // ---- illegal re-request ----
    do_reset();
    cnt_a = 0;
    bus.req_x_vld[1] = 1'b1;
    bus.req_x[1]     = 32'd81;
    step();
    bus.req_x_vld = '0;
    if (bus.isqrt_x_vld) cnt_a++;
    step();
    if (bus.isqrt_x_vld) cnt_a++;
    chk("illegal_err_before", 64'(bus.err), 64'(0));
    bus.req_x_vld[1] = 1'b1;
    bus.req_x[1]     = 32'd5;
    step();
    bus.req_x_vld = '0;
    chk("illegal_err_set", 64'(bus.err), 64'(1));
    for (int c = 3; c < 6; c++) begin
      if (bus.isqrt_x_vld) cnt_a++;
      step();
    end
    chk("illegal_res_vld", 64'(bus.req_y_vld), 64'(3'b010));
    chk("illegal_res_y",   64'(bus.req_y),     64'(9));
    cnt_b = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.req_y_vld != '0) cnt_b++;
      if (bus.isqrt_x_vld) cnt_a++;
    end
    chk("illegal_issue_count", 64'(cnt_a),   64'(1));
    chk("illegal_extra_res",   64'(cnt_b),   64'(0));
    chk("illegal_err_sticky",  64'(bus.err), 64'(1));

    // ---- spurious isqrt result with the FIFO empty ----
    do_reset();
    spur = 1'b1;
    chk("spur_err_before", 64'(bus.err), 64'(0));
    step();
    spur = 1'b0;
    chk("spur_err_set",  64'(bus.err),       64'(1));
    chk("spur_no_vld1",  64'(bus.req_y_vld), 64'(0));
    step();
    chk("spur_no_vld2",  64'(bus.req_y_vld), 64'(0));
    chk("spur_busy",     64'(bus.busy),      64'(0));

    // ---- asynchronous reset with two operations in flight ----
    do_reset();
    bus.req_x_vld = 3'b011;
    bus.req_x[0]  = 32'd16;
    bus.req_x[1]  = 32'd81;
    step();
    bus.req_x_vld = '0;
    step();
    chk("mid_issue_vld", 64'(bus.isqrt_x_vld), 64'(1));
    chk("mid_busy",      64'(bus.busy),        64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y_vld", 64'(bus.req_y_vld),   64'(0));
    chk("mid_rst_y",     64'(bus.req_y),       64'(0));
    chk("mid_rst_x_vld", 64'(bus.isqrt_x_vld), 64'(0));
    chk("mid_rst_x",     64'(bus.isqrt_x),     64'(0));
    chk("mid_rst_busy",  64'(bus.busy),        64'(0));
    chk("mid_rst_err",   64'(bus.err),         64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_x_vld[2] = 1'b1;
    bus.req_x[2]     = 32'd1024;
    step();
    bus.req_x_vld = '0;
    n = 1;
    while (bus.req_y_vld == '0 && n < 20) begin
      step();
      n++;
    end
    chk("post_rst_latency", 64'(n),             64'(6));
    chk("post_rst_vld",     64'(bus.req_y_vld), 64'(3'b100));
    chk("post_rst_y",       64'(bus.req_y),     64'(32));
    step();
    chk("post_rst_idle",    64'(bus.busy),      64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_isqrt_share_arbiter
`default_nettype wire

// File: doc/isqrt_share_arbiter.md
Name: isqrt_share_arbiter

Overview:
- Shares one isqrt instance among N_REQ independent requesters, e.g. several formula FSMs that each issue one isqrt_x_vld pulse and then wait for isqrt_y_vld.
- Buffers each request in a per-requester slot and issues to isqrt in round-robin order.
- Records the requester ID of every issued operation in an in-order tag FIFO, and routes each isqrt result back to the requester that owns it.
- Sits between the requester FSMs and the single pipelined isqrt instance; neither side has backpressure.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ID_W, $clog2(N_REQ), requester ID width; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous assert, active-low; the isqrt instance shares this reset.
- req_x_vld  input  N_REQ  one-cycle request pulse per requester.
- req_x  input  N_REQ x 32  operand per requester; sampled when the matching req_x_vld is high.
- req_y_vld  output  N_REQ  one-hot, one-cycle result strobe.
- req_y  output  16  result value, shared by all requesters; meaningful only while some req_y_vld bit is high.
- isqrt_x_vld  output  1  issue strobe to isqrt.
- isqrt_x  output  32  operand to isqrt.
- isqrt_y_vld  input  1  result strobe from isqrt; fixed latency, in order.
- isqrt_y  input  16  result from isqrt.
- busy  output  1  high while any slot is pending or any tag is in flight.
- err  output  1  sticky protocol-violation flag; cleared only by reset.

Behaviour:
- Reset values: all slots empty, all outstanding flags 0, tag FIFO empty, RR pointer 0. req_y_vld=0, req_y=0, isqrt_x_vld=0, isqrt_x=0, busy=0, err=0.
- Slot capture:
  - req_x_vld[i] at edge t stores req_x[i] in slot i and sets pending[i] and outstanding[i].
  - If outstanding[i] is already set: request dropped, err set.
- Issue (combinational from registered state):
  - Grant = first pending slot found scanning from rr_ptr, wrapping modulo N_REQ.
  - If a grant exists: isqrt_x_vld=1, isqrt_x=slot value.
  - At the edge: pending[grant] cleared, grant ID pushed to the tag FIFO, rr_ptr = grant+1 mod N_REQ.
  - If nothing is pending: isqrt_x_vld=0, isqrt_x=0, rr_ptr holds.
  - At most one issue per cycle.
  - A request captured at edge t is issued no earlier than the cycle after edge t.
- Return path (registered):
  - isqrt_y_vld at cycle c pops the head ID h.
  - Cycle c+1: req_y_vld = one-hot(h), req_y = isqrt_y; outstanding[h] cleared at that edge.
  - Requester h may send a new request in cycle c+1 or later.
- Latency: request pulse cycle t, isqrt issue cycle t+1 when uncontended, result to requester cycle t+2+L, where L is the isqrt latency.
- Tag FIFO:
  - Depth N_REQ, which is sufficient because each requester has at most one operation in flight.
  - Simultaneous push and pop in one cycle is legal; count is unchanged.
  - isqrt_y_vld while the FIFO is empty: err set, result discarded, req_y_vld stays 0.
  - Push while full cannot occur and is covered by an assertion.
- Simultaneous events:
  - All N_REQ requests in one cycle are captured together, then issued over N_REQ consecutive cycles in RR order.
  - Capture and issue of different slots in the same cycle are independent.
- busy = any pending OR FIFO not empty.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). The isqrt instance is reset with it, so no stale result arrives afterwards.

Decomposition:
- Package isqrt_arb_pkg:
  - default N_REQ;
  - typedef of the 32-bit operand and 16-bit result;
  - function computing the next RR grant.
- Sub-module isqrt_tag_fifo: parameterised width ID_W and depth, with push, pop, head, empty, full.
- Arbiter top: slots, RR pointer, return register, err logic.

Test Plan:
- Single request, L=4: req_x_vld[0] with x=49 in cycle 0 -> isqrt_x_vld cycle 1 with x=49; req_y_vld=001 with req_y=7 in cycle 6; busy low from cycle 6.
- Three requests in one cycle, rr_ptr=0, x={16,81,144} -> issue order ID0 16, ID1 81, ID2 144 in cycles 1..3; results 4, 9, 12 routed in that order with one-hot strobes 001, 010, 100.
- Fairness: requester 0 re-requests as soon as each of its results arrives, requester 2 requests once -> requester 2 issued by its second arbitration opportunity; no starvation over 100 cycles.
- Illegal re-request: requester 1 pulses req_x_vld again before its result returns -> err=1 and stays 1; the first result is still delivered correctly.
- Spurious isqrt_y_vld with the FIFO empty -> err=1, no req_y_vld.
- rst_n pulled low while two operations are in flight -> all outputs 0 at once; after release, a fresh request x=1024 returns 32.
